// File: rtl/simon64_96_decrypt.sv
// SIMON64/96 decryption core: on-chip key expansion into a key store, then one
// inverse round per cycle with a valid/ready handshake on key, ciphertext and plaintext.
module simon64_96_decrypt #(
  parameter int ROUNDS = 42
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  output logic        key_ready,
  input  logic [95:0] key,
  input  logic        ct_valid,
  output logic        ct_ready,
  input  logic [63:0] ct,
  output logic        pt_valid,
  input  logic        pt_ready,
  output logic [63:0] pt,
  output logic        busy
);

  localparam int IW = $clog2(ROUNDS);
  // z2 sequence as written, leftmost character is sequence element 0
  localparam logic [61:0] Z2_TEXT =
    62'b10101111011100000011010010011000101000010001111110010110110011;

  typedef enum logic [2:0] {IDLE, EXPAND, KEYED, DECRYPT, DONE} state_t;

  state_t        r_state;
  logic [IW-1:0] r_idx;
  logic [5:0]    r_zidx;
  logic [31:0]   r_km1;
  logic [31:0]   r_km2;
  logic [31:0]   r_km3;
  logic [31:0]   r_x;
  logic [31:0]   r_y;
  logic          r_key_ready;
  logic          r_pt_valid;
  logic [63:0]   r_pt;

  logic [31:0]   r_klo [3];
  logic [31:0]   r_kmem [ROUNDS];
  logic [31:0]   r_ram_q;
  logic          r_lo_sel;
  logic [1:0]    r_lo_idx;

  logic [61:0]   w_z2;
  logic          w_zbit;
  logic          w_key_hs;
  logic          w_ct_hs;
  logic [31:0]   w_tmp0;
  logic [31:0]   w_tmp;
  logic [31:0]   w_k_new;
  logic [31:0]   w_f;
  logic [31:0]   w_rk;
  logic [31:0]   w_y_new;
  logic [IW-1:0] w_rd_addr;

  function automatic logic [31:0] rol(input logic [31:0] v, input int r);
    return (v << r) | (v >> (32 - r));
  endfunction

  // Re-index z2 so that bit j of w_z2 is sequence element j
  for (genvar gi = 0; gi < 62; gi++) begin : g_z2
    assign w_z2[gi] = Z2_TEXT[61-gi];
  end

  assign w_zbit   = w_z2[r_zidx];
  assign w_key_hs = key_valid && r_key_ready;
  assign ct_ready = (r_state == KEYED) && !key_valid;
  assign w_ct_hs  = ct_valid && ct_ready;

  // Key schedule step: the three most recent words live in r_km1..r_km3
  assign w_tmp0  = rol(r_km1, 29);
  assign w_tmp   = w_tmp0 ^ rol(w_tmp0, 31);
  assign w_k_new = ~r_km3 ^ w_tmp ^ {31'b0, w_zbit} ^ 32'd3;

  // Inverse round: (x,y) <- (y, x ^ f(y) ^ k)
  assign w_f     = (rol(r_y, 1) & rol(r_y, 8)) ^ rol(r_y, 2);
  assign w_y_new = r_x ^ w_f ^ w_rk;

  // Read one round key ahead; outside DECRYPT prefetch the first key used
  assign w_rd_addr = (r_state == DECRYPT && r_idx != '0) ? r_idx - 1'b1
                                                         : IW'(ROUNDS - 1);

  // Key words 0..2 arrive together, so they sit in flops beside the single-port store
  always_ff @(posedge clk) begin
    if (w_key_hs) begin
      for (int i = 0; i < 3; i++) begin
        r_klo[i] <= key[32*i +: 32];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == EXPAND) begin
      r_kmem[r_idx] <= w_k_new;
    end
    r_ram_q  <= r_kmem[w_rd_addr];
    r_lo_sel <= (w_rd_addr < IW'(3));
    r_lo_idx <= w_rd_addr[1:0];
  end

  assign w_rk = r_lo_sel ? r_klo[r_lo_idx] : r_ram_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_zidx      <= '0;
      r_km1       <= '0;
      r_km2       <= '0;
      r_km3       <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_key_ready <= 1'b0;
      r_pt_valid  <= 1'b0;
      r_pt        <= '0;
    end else begin
      case (r_state)
        IDLE, KEYED: begin
          r_key_ready <= 1'b1;
          if (w_key_hs) begin
            r_km3       <= key[31:0];
            r_km2       <= key[63:32];
            r_km1       <= key[95:64];
            r_idx       <= IW'(3);
            r_zidx      <= '0;
            r_key_ready <= 1'b0;
            r_state     <= EXPAND;
          end else if (w_ct_hs) begin
            r_x         <= ct[63:32];
            r_y         <= ct[31:0];
            r_idx       <= IW'(ROUNDS - 1);
            r_key_ready <= 1'b0;
            r_state     <= DECRYPT;
          end
        end

        EXPAND: begin
          r_km3  <= r_km2;
          r_km2  <= r_km1;
          r_km1  <= w_k_new;
          r_zidx <= (r_zidx == 6'd61) ? 6'd0 : r_zidx + 6'd1;
          if (r_idx == IW'(ROUNDS - 1)) begin
            r_key_ready <= 1'b1;
            r_state     <= KEYED;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end

        DECRYPT: begin
          r_x <= r_y;
          r_y <= w_y_new;
          if (r_idx == '0) begin
            r_pt       <= {r_y, w_y_new};
            r_pt_valid <= 1'b1;
            r_state    <= DONE;
          end else begin
            r_idx <= r_idx - 1'b1;
          end
        end

        DONE: begin
          if (pt_ready) begin
            r_pt_valid  <= 1'b0;
            r_key_ready <= 1'b1;
            r_state     <= KEYED;
          end
        end

        default: begin
          r_key_ready <= 1'b0;
          r_pt_valid  <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign key_ready = r_key_ready;
  assign pt_valid  = r_pt_valid;
  assign pt        = r_pt;
  assign busy      = (r_state == EXPAND) || (r_state == DECRYPT) || (r_state == DONE);

endmodule

// File: tb/tb_simon64_96_decrypt.sv
// Scoreboard bench for simon64_96_decrypt: known answer, key reuse, backpressure,
// key/ct collision, mid-run reset, ignored key and randomized traffic vs a reference model.
module tb_simon64_96_decrypt;

  localparam int          ROUNDS  = 42;
  localparam logic [95:0] KAT_KEY = 96'h13121110_0b0a0908_03020100;
  localparam logic [63:0] KAT_CT  = 64'h5ca2e27f_111a8fc8;
  localparam logic [63:0] KAT_PT  = 64'h6f722067_6e696c63;

  logic        clk;
  logic        rst_n;
  logic        key_valid;
  logic        key_ready;
  logic [95:0] key;
  logic        ct_valid;
  logic        ct_ready;
  logic [63:0] ct;
  logic        pt_valid;
  logic        pt_ready;
  logic [63:0] pt;
  logic        busy;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] sb[$];
  int          rdy_mode = 0;   // 0: always ready, 1: hold off, 2: random
  logic [95:0] cur_key;

  simon64_96_decrypt #(.ROUNDS(ROUNDS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_valid(key_valid),
    .key_ready(key_ready),
    .key      (key),
    .ct_valid (ct_valid),
    .ct_ready (ct_ready),
    .ct       (ct),
    .pt_valid (pt_valid),
    .pt_ready (pt_ready),
    .pt       (pt),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rol32(input logic [31:0] v, input int r);
    return (v << r) | (v >> (32 - r));
  endfunction

  // Reference: expand the schedule from the textual z2 sequence, then undo the rounds
  function automatic logic [63:0] model_decrypt(input logic [95:0] k, input logic [63:0] c);
    string       z2 = "10101111011100000011010010011000101000010001111110010110110011";
    logic [31:0] ks [ROUNDS];
    logic [31:0] t;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] nx;
    logic [31:0] zb;
    ks[0] = k[31:0];
    ks[1] = k[63:32];
    ks[2] = k[95:64];
    for (int i = 3; i < ROUNDS; i++) begin
      t  = rol32(ks[i-1], 32 - 3);
      t  = t ^ rol32(t, 32 - 1);
      zb = (z2[(i-3) % 62] == 8'h31) ? 32'd1 : 32'd0;
      ks[i] = ~ks[i-3] ^ t ^ zb ^ 32'd3;
    end
    x = c[63:32];
    y = c[31:0];
    for (int r = ROUNDS - 1; r >= 0; r--) begin
      nx = y;
      y  = x ^ ((rol32(y, 1) & rol32(y, 8)) ^ rol32(y, 2)) ^ ks[r];
      x  = nx;
    end
    return {x, y};
  endfunction

  // pt_ready driver, offset from the stimulus drive point
  initial begin
    pt_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       pt_ready = 1'b1;
        1:       pt_ready = 1'b0;
        default: pt_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: every plaintext handshake pops one expected value
  initial begin
    logic [63:0] exp;
    forever begin
      @(negedge clk);
      if (rst_n && pt_valid && pt_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL pt_unexpected: got %h, expected no output", pt);
        end else begin
          exp = sb.pop_front();
          $display("pt %h expected %h", pt, exp);
          chk("pt", pt, exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [95:0] k);
    int n;
    n = 0;
    key = k;
    key_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (key_ready) break;
      n++;
      if (n > 300) begin
        chk("key_ready_timeout", 64'(key_ready), 64'd1);
        key_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    cur_key = k;
    #1;
    key_valid = 1'b0;
  endtask

  task automatic wait_expand();
    int n;
    n = 0;
    while (n <= 200) begin
      @(negedge clk);
      if (n == 0) chk("busy_in_expand", 64'({busy, key_ready}), 64'b10);
      if (key_ready) break;
      @(posedge clk);
      n++;
    end
    chk("expand_cycles", 64'(n), 64'(ROUNDS - 3));
    tick();
  endtask

  task automatic send_ct(input logic [63:0] c, input logic [63:0] exp, output int n);
    n = 0;
    ct = c;
    ct_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (ct_ready) break;
      n++;
      if (n > 300) begin
        chk("ct_ready_timeout", 64'(ct_ready), 64'd1);
        ct_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    sb.push_back(exp);
    #1;
    ct_valid = 1'b0;
  endtask

  task automatic wait_pt(output int lat);
    int n;
    n = 0;
    while (n <= 200) begin
      @(negedge clk);
      if (pt_valid) break;
      @(posedge clk);
      n++;
    end
    lat = n + 1;
  endtask

  task automatic wait_keyed();
    int n;
    n = 0;
    while (n <= 300) begin
      @(negedge clk);
      if (key_ready && !busy) break;
      n++;
    end
    if (n > 300) chk("keyed_timeout", 64'(busy), 64'd0);
    tick();
  endtask

  initial begin
    int          lat;
    int          nw;
    int          n;
    logic [63:0] hold_pt;
    logic [63:0] rc;
    logic [95:0] rk;

    rst_n     = 1'b0;
    key_valid = 1'b0;
    key       = '0;
    ct_valid  = 1'b0;
    ct        = '0;
    cur_key   = '0;

    repeat (3) @(negedge clk);
    chk("reset_flags", 64'({key_ready, ct_ready, pt_valid, busy}), 64'd0);
    chk("reset_pt", pt, 64'd0);
    tick();
    rst_n = 1'b1;

    // Known answer and latency
    load_key(KAT_KEY);
    wait_expand();
    send_ct(KAT_CT, KAT_PT, nw);
    wait_pt(lat);
    chk("kat_latency", 64'(lat), 64'(ROUNDS + 1));
    wait_keyed();

    // Key reuse: ciphertext accepted at once, no expansion
    send_ct(KAT_CT, KAT_PT, nw);
    chk("reuse_no_wait", 64'(nw), 64'd0);
    wait_pt(lat);
    chk("reuse_latency", 64'(lat), 64'(ROUNDS + 1));
    wait_keyed();

    // Backpressure
    rdy_mode = 1;
    tick();
    tick();
    rc = {$urandom, $urandom};
    send_ct(rc, model_decrypt(cur_key, rc), nw);
    wait_pt(lat);
    hold_pt = pt;
    chk("bp_pt_model", hold_pt, model_decrypt(cur_key, rc));
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_hold", 64'({pt_valid, ct_ready, key_ready, busy}), 64'b1001);
      chk("bp_pt_stable", pt, hold_pt);
      @(posedge clk);
    end
    #1;
    rdy_mode = 0;
    @(negedge clk);
    chk("bp_ready_seen", 64'({pt_ready, pt_valid}), 64'b11);
    @(negedge clk);
    chk("bp_release", 64'({pt_valid, busy, key_ready}), 64'b001);
    tick();

    // Collision: key wins, ciphertext waits through the expansion
    rk = {$urandom, $urandom, $urandom};
    rc = {$urandom, $urandom};
    key = rk;
    key_valid = 1'b1;
    ct = rc;
    ct_valid = 1'b1;
    @(negedge clk);
    chk("coll_ready", 64'({ct_ready, key_ready}), 64'b01);
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    cur_key = rk;
    n = 0;
    while (n <= 200) begin
      @(negedge clk);
      if (ct_ready) break;
      @(posedge clk);
      n++;
    end
    chk("coll_wait", 64'(n), 64'(ROUNDS - 3));
    @(posedge clk);
    sb.push_back(model_decrypt(rk, rc));
    #1;
    ct_valid = 1'b0;
    wait_pt(lat);
    chk("coll_latency", 64'(lat), 64'(ROUNDS + 1));
    wait_keyed();

    // Key pulse during DECRYPT is ignored
    load_key(KAT_KEY);
    wait_expand();
    send_ct(KAT_CT, KAT_PT, nw);
    repeat (5) tick();
    key = {$urandom, $urandom, $urandom};
    key_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ignored_key_ready", 64'({key_ready, busy}), 64'b01);
      tick();
    end
    key_valid = 1'b0;
    wait_pt(lat);
    wait_keyed();

    // Reset around round 20
    send_ct(KAT_CT, KAT_PT, nw);
    repeat (20) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_flags", 64'({key_ready, ct_ready, pt_valid, busy}), 64'd0);
    chk("midrst_pt", pt, 64'd0);
    sb.delete();
    ct = KAT_CT;
    ct_valid = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("post_rst_no_ct", 64'({ct_ready, busy}), 64'd0);
      tick();
    end
    ct_valid = 1'b0;
    load_key(KAT_KEY);
    wait_expand();
    send_ct(KAT_CT, KAT_PT, nw);
    wait_pt(lat);
    chk("rerun_latency", 64'(lat), 64'(ROUNDS + 1));
    wait_keyed();

    // Randomized traffic with random consumer stalls
    rdy_mode = 2;
    for (int kk = 0; kk < 3; kk++) begin
      load_key({$urandom, $urandom, $urandom});
      wait_expand();
      for (int j = 0; j < 5; j++) begin
        repeat ($urandom_range(0, 3)) tick();
        rc = {$urandom, $urandom};
        send_ct(rc, model_decrypt(cur_key, rc), nw);
      end
    end
    rdy_mode = 0;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/simon64_96_decrypt.md
SIMON64_96_DECRYPT -- requirements
Module: simon64_96_decrypt

Interface
REQ-001 Parameter: ROUNDS, default 42, number of SIMON64/96 rounds; key store depth equals ROUNDS.
REQ-002 Ports, one per line:
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- key_valid  input  1  key offered.
- key_ready  output  1  key accepted this cycle if key_valid is high.
- key  input  96  key words k2|k1|k0 = key[95:64]|key[63:32]|key[31:0].
- ct_valid  input  1  ciphertext offered.
- ct_ready  output  1  ciphertext accepted this cycle if ct_valid is high.
- ct  input  64  ciphertext x|y = ct[63:32]|ct[31:0].
- pt_valid  output  1  plaintext valid.
- pt_ready  input  1  consumer accepts plaintext.
- pt  output  64  plaintext x|y = pt[63:32]|pt[31:0].
- busy  output  1  high in EXPAND, DECRYPT and DONE.
REQ-003 The block SHALL use one clock, clk, and an asynchronous active-low reset, rst_n.

Function
REQ-004 FSM states SHALL be IDLE, EXPAND, KEYED, DECRYPT and DONE; all outputs SHALL be registered or decoded from state only, except ct_ready.
REQ-005 key_ready SHALL be 1 in IDLE and KEYED, else 0; a key handshake SHALL load k0..k2 into store entries 0..2, clear the expansion index to 3, and enter EXPAND.
REQ-006 EXPAND SHALL produce one key per cycle: tmp = ROR3(k[i-1]) ^ k[i-3]... specifically tmp = ROR3(k[i-1]); tmp = tmp ^ ROR1(tmp); k[i] = ~k[i-3] ^ tmp ^ z2[(i-3) mod 62] ^ 3, for i = 3..ROUNDS-1.
REQ-007 z2 SHALL be the 62-bit constant 10101111011100000011010010011000101000010001111110010110110011 (bit 0 leftmost).
REQ-008 EXPAND SHALL last exactly ROUNDS-3 cycles (39 by default), then go to KEYED.
REQ-009 ct_ready SHALL equal (state==KEYED) && !key_valid; when key_valid and ct_valid are both high in KEYED, the key SHALL win and the ciphertext SHALL NOT be consumed.
REQ-010 A ct handshake SHALL load x=ct[63:32], y=ct[31:0], set round index to ROUNDS-1, and enter DECRYPT.
REQ-011 Each DECRYPT cycle SHALL apply (x,y) <- (y, x ^ f(y) ^ k[idx]), with f(v) = (ROL1(v) & ROL8(v)) ^ ROL2(v), then decrement idx.
REQ-012 After exactly ROUNDS DECRYPT cycles, the block SHALL enter DONE with pt = {x,y} and pt_valid = 1.
REQ-013 Latency SHALL be ROUNDS+1 edges from ct handshake edge to first edge where pt_valid is sampled high (43 by default).
REQ-014 In DONE, pt and pt_valid SHALL hold stable until pt_ready is high; on that edge the block SHALL return to KEYED with pt_valid = 0.
REQ-015 The key store SHALL persist across ciphertexts; a new key is taken only in IDLE or KEYED; key_valid in EXPAND, DECRYPT or DONE SHALL be ignored.
REQ-016 Round and expansion indices SHALL never wrap; idx underflow past 0 SHALL NOT occur (transition at idx==0).

Reset
REQ-017 rst_n low SHALL asynchronously force IDLE, key_ready=0 while low, ct_ready=0, pt_valid=0, pt=0, busy=0.
REQ-018 Reset mid-EXPAND or mid-DECRYPT SHALL abort; after release the block SHALL be in IDLE and require a new key before accepting ciphertext.
REQ-019 Key store contents need not be cleared by reset.

Verification
REQ-020 Known answer: key=96'h13121110_0b0a0908_03020100, then ct=64'h5ca2e27f_111a8fc8 -> pt=64'h6f722067_6e696c63 with pt_valid rising 43 edges after ct handshake.
REQ-021 Key reuse: after REQ-020, send the same ct again with no new key -> identical pt; no EXPAND cycles.
REQ-022 Backpressure: hold pt_ready=0 for 10 cycles in DONE -> pt and pt_valid stable; ct_ready=0 throughout; KEYED one cycle after pt_ready=1.
REQ-023 Collision: in KEYED, assert key_valid and ct_valid together -> ct_ready=0, EXPAND entered, ct still pending; it is accepted after 39 cycles.
REQ-024 Reset at DECRYPT round 20 -> all outputs 0 immediately; ct_valid ignored until a key is loaded; rerun of REQ-020 passes.
REQ-025 Ignored key: pulse key_valid with a different key during DECRYPT -> output still matches REQ-020 pt.
